// File: rtl/jcy_predictor.sv
// jcy_predictor: direction predictor for the JCY (jump-on-carry)
// microinstruction. A table of 2-bit saturating counters, indexed by the low
// address bits of the fetched JCY, supplies the predicted direction. The
// checker's verdict trains the table, raises a one-cycle flush on a
// mispredict and feeds saturating hit/miss statistics. Only one JCY may be
// outstanding; a second JCY fetch is stalled until the first one resolves.
module jcy_predictor #(
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter logic [6:0]  JCY_OP   = 7'b1010000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [6:0]  fetch_T,
  input  logic [15:0] fetch_W,
  output logic        stall,
  output logic        pred_valid,
  output logic        last_pred,
  output logic [1:0]  pred_type,
  input  logic        checked,
  input  logic        incorrect_pred,
  input  logic        correct_pred,
  output logic        flush,
  output logic        redirect_taken,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [1:0]         r_ctr [DEPTH];
  logic [IDX_W-1:0]   r_pendIdx;
  logic               r_lastPred;
  logic [1:0]         r_predType;
  logic               r_flush;
  logic               r_redirectTaken;
  logic [15:0]        r_hitCnt;
  logic [15:0]        r_missCnt;

  logic               w_isJcy;
  logic               w_accept;
  logic               w_resolve;
  logic               w_stall;
  logic               w_predValid;
  logic [IDX_W-1:0]   w_fetchIdx;
  logic [1:0]         w_readCtr;
  logic [1:0]         w_pendCtr;
  logic [1:0]         w_ctrNext;
  logic               w_unusedAddrBits;

  // Address bits above the index are deliberately ignored (aliasing is intended).
  assign w_unusedAddrBits = ^fetch_W[15:IDX_W];

  assign w_isJcy    = fetch_valid && (fetch_T == JCY_OP);
  assign w_fetchIdx = fetch_W[IDX_W-1:0];
  assign w_readCtr  = r_ctr[w_fetchIdx];
  assign w_pendCtr  = r_ctr[r_pendIdx];

  // State register; a reset drops any outstanding prediction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the combinational stall / accept / resolve strobes.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_predValid = 1'b0;
    w_accept    = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_isJcy) begin
          w_accept    = 1'b1;
          w_nextState = PENDING;
        end
      end
      PENDING: begin
        w_predValid = 1'b1;
        w_stall     = w_isJcy;
        if (checked) begin
          w_resolve   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Saturating train step for the counter of the outstanding prediction.
  always_comb begin
    w_ctrNext = w_pendCtr;
    if (correct_pred) begin
      if (w_pendCtr != 2'b11) begin
        w_ctrNext = w_pendCtr + 2'b01;
      end
    end else begin
      if (w_pendCtr != 2'b00) begin
        w_ctrNext = w_pendCtr - 2'b01;
      end
    end
  end

  // Counter table: reset to the weak initial value, trained only on resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CNT_INIT;
      end
    end else if (w_resolve) begin
      r_ctr[r_pendIdx] <= w_ctrNext;
    end
  end

  // Capture the prediction on accept and hold it until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pendIdx  <= '0;
      r_lastPred <= 1'b0;
      r_predType <= 2'b00;
    end else if (w_accept) begin
      r_pendIdx  <= w_fetchIdx;
      r_lastPred <= w_readCtr[1];
      r_predType <= w_readCtr;
    end
  end

  // One-cycle flush pulse with the correct direction on a mispredict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush         <= 1'b0;
      r_redirectTaken <= 1'b0;
    end else begin
      r_flush <= w_resolve && incorrect_pred;
      if (w_resolve && incorrect_pred) begin
        r_redirectTaken <= correct_pred;
      end
    end
  end

  // Saturating hit/miss statistics, stepped once per resolved prediction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hitCnt  <= 16'd0;
      r_missCnt <= 16'd0;
    end else if (w_resolve) begin
      if (incorrect_pred) begin
        if (r_missCnt != 16'hFFFF) begin
          r_missCnt <= r_missCnt + 16'd1;
        end
      end else begin
        if (r_hitCnt != 16'hFFFF) begin
          r_hitCnt <= r_hitCnt + 16'd1;
        end
      end
    end
  end

  assign stall          = w_stall;
  assign pred_valid     = w_predValid;
  assign last_pred      = r_lastPred;
  assign pred_type      = r_predType;
  assign flush          = r_flush;
  assign redirect_taken = r_redirectTaken;
  assign hit_cnt        = r_hitCnt;
  assign miss_cnt       = r_missCnt;

endmodule

// File: tb/tb_jcy_predictor.sv
// tb_jcy_predictor: directed scenarios followed by random traffic, all
// compared against a transaction-level reference model of the predictor.
module tb_jcy_predictor;

  localparam logic [6:0] JCY = 7'b1010000;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [6:0]  fetch_T;
  logic [15:0] fetch_W;
  logic        stall;
  logic        pred_valid;
  logic        last_pred;
  logic [1:0]  pred_type;
  logic        checked;
  logic        incorrect_pred;
  logic        correct_pred;
  logic        flush;
  logic        redirect_taken;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state: plain integers, one counter per table entry.
  int modelCtr [16];
  bit modelPending;
  int modelIdx;
  int modelPredType;
  bit modelLastPred;
  bit modelFlush;
  bit modelRedirect;
  int modelHit;
  int modelMiss;

  jcy_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_T        (fetch_T),
    .fetch_W        (fetch_W),
    .stall          (stall),
    .pred_valid     (pred_valid),
    .last_pred      (last_pred),
    .pred_type      (pred_type),
    .checked        (checked),
    .incorrect_pred (incorrect_pred),
    .correct_pred   (correct_pred),
    .flush          (flush),
    .redirect_taken (redirect_taken),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance the reference model by one rising edge with the given inputs.
  task automatic modelEdge(input bit rstn, input bit fv, input logic [6:0] ft,
                           input logic [15:0] fw, input bit chk, input bit inc, input bit cor);
    bit isJcy;
    isJcy = fv && (ft == JCY);
    if (!rstn) begin
      foreach (modelCtr[i]) modelCtr[i] = 1;
      modelPending  = 0;
      modelIdx      = 0;
      modelPredType = 0;
      modelLastPred = 0;
      modelFlush    = 0;
      modelRedirect = 0;
      modelHit      = 0;
      modelMiss     = 0;
    end else begin
      modelFlush = 0;
      if (!modelPending) begin
        if (isJcy) begin
          modelIdx      = fw % 16;
          modelPredType = modelCtr[modelIdx];
          modelLastPred = (modelCtr[modelIdx] >= 2);
          modelPending  = 1;
        end
      end else if (chk) begin
        if (cor) modelCtr[modelIdx] = (modelCtr[modelIdx] + 1 > 3) ? 3 : modelCtr[modelIdx] + 1;
        else     modelCtr[modelIdx] = (modelCtr[modelIdx] - 1 < 0) ? 0 : modelCtr[modelIdx] - 1;
        if (inc) begin
          modelFlush    = 1;
          modelRedirect = cor;
          modelMiss     = (modelMiss + 1 > 65535) ? 65535 : modelMiss + 1;
        end else begin
          modelHit = (modelHit + 1 > 65535) ? 65535 : modelHit + 1;
        end
        modelPending = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, check stall before the edge and state after it.
  task automatic applyStimulus(input bit rstn, input bit fv, input logic [6:0] ft,
                               input logic [15:0] fw, input bit chk, input bit inc, input bit cor);
    @(negedge clk);
    rst_n          = rstn;
    fetch_valid    = fv;
    fetch_T        = ft;
    fetch_W        = fw;
    checked        = chk;
    incorrect_pred = inc;
    correct_pred   = cor;
    #1;
    checkOutput("stall", int'(stall), int'(modelPending && fv && (ft == JCY)));
    @(posedge clk);
    modelEdge(rstn, fv, ft, fw, chk, inc, cor);
    #1;
    checkOutput("pred_valid", int'(pred_valid), int'(modelPending));
    checkOutput("last_pred", int'(last_pred), int'(modelLastPred));
    checkOutput("pred_type", int'(pred_type), modelPredType);
    checkOutput("flush", int'(flush), int'(modelFlush));
    if (modelFlush) checkOutput("redirect_taken", int'(redirect_taken), int'(modelRedirect));
    checkOutput("hit_cnt", int'(hit_cnt), modelHit);
    checkOutput("miss_cnt", int'(miss_cnt), modelMiss);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 7'd0, 16'd0, 0, 0, 0);
  endtask

  task automatic fetchJcy(input logic [15:0] w);
    applyStimulus(1, 1, JCY, w, 0, 0, 0);
  endtask

  // Resolve with the actual direction; mispredict flag derived from the model.
  task automatic resolveDir(input bit taken);
    applyStimulus(1, 0, 7'd0, 16'd0, 1, (taken != modelLastPred), taken);
  endtask

  initial begin
    rst_n = 0; fetch_valid = 0; fetch_T = 0; fetch_W = 0;
    checked = 0; incorrect_pred = 0; correct_pred = 0;

    // Reset held for two cycles, then an immediate JCY at W=0.
    applyStimulus(0, 0, 7'd0, 16'd0, 0, 0, 0);
    applyStimulus(0, 0, 7'd0, 16'd0, 0, 0, 0);
    fetchJcy(16'h0000);
    checkOutput("reset_pred_type", int'(pred_type), 1);
    resolveDir(0);

    // Miss then train at index 3.
    fetchJcy(16'h0003);
    applyStimulus(1, 0, 7'd0, 16'd0, 1, 1, 1);
    checkOutput("miss_flush", int'(flush), 1);
    checkOutput("miss_redirect", int'(redirect_taken), 1);
    idleCycle();
    fetchJcy(16'h0003);
    checkOutput("trained_pred_type", int'(pred_type), 2);
    resolveDir(1);

    // Saturation upward, aliasing, then saturation downward.
    for (int i = 0; i < 4; i++) begin
      fetchJcy(16'h0003);
      resolveDir(1);
    end
    fetchJcy(16'h0013);
    checkOutput("alias_pred_type", int'(pred_type), 3);
    resolveDir(0);
    for (int i = 0; i < 4; i++) begin
      fetchJcy(16'h0003);
      resolveDir(0);
    end
    fetchJcy(16'h0003);
    checkOutput("floor_pred_type", int'(pred_type), 0);
    resolveDir(0);

    // Stall: JCY held during PENDING, including the resolving cycle.
    fetchJcy(16'h0005);
    for (int i = 0; i < 3; i++) fetchJcy(16'h0007);
    applyStimulus(1, 1, 7'h11, 16'h0007, 0, 0, 0);
    applyStimulus(1, 1, JCY, 16'h0007, 1, 0, 0);
    fetchJcy(16'h0007);
    checkOutput("accept_after_stall", int'(pred_valid), 1);
    resolveDir(1);

    // Reset mid-PENDING, then a late verdict must be ignored.
    fetchJcy(16'h0002);
    applyStimulus(0, 0, 7'd0, 16'd0, 0, 0, 0);
    applyStimulus(1, 0, 7'd0, 16'd0, 1, 1, 1);
    fetchJcy(16'h0002);
    checkOutput("post_reset_ctr2", int'(pred_type), 1);
    resolveDir(0);

    // Spurious verdicts while IDLE.
    applyStimulus(1, 0, 7'd0, 16'd0, 1, 1, 1);
    applyStimulus(1, 0, 7'd0, 16'd0, 1, 1, 0);

    // Miss counter saturation: preload near the top, then keep missing.
    force dut.r_missCnt = 16'hFFFE;
    #1;
    release dut.r_missCnt;
    modelMiss = 65534;
    for (int i = 0; i < 3; i++) begin
      fetchJcy(16'h0009);
      applyStimulus(1, 0, 7'd0, 16'd0, 1, 1, ~modelLastPred);
    end
    checkOutput("miss_saturated", int'(miss_cnt), 65535);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit       rr;
      bit       fv;
      bit       chk;
      bit       cor;
      bit       inc;
      logic [6:0]  ft;
      logic [15:0] fw;
      rr  = ($urandom_range(0, 59) != 0);
      fv  = $urandom_range(0, 1);
      ft  = ($urandom_range(0, 2) != 0) ? JCY : 7'($urandom);
      fw  = 16'($urandom);
      chk = $urandom_range(0, 1);
      cor = $urandom_range(0, 1);
      inc = modelPending ? (cor != modelLastPred) : 1'($urandom_range(0, 1));
      applyStimulus(rr, fv, ft, fw, chk, inc, cor);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
